// File: rtl/int_mul_alu_shared_wb.sv
// -----------------------------------------------------------------------------
// int_mul_alu_shared_wb
//
// Integer execution unit for the int0 issue slot. It contains a single-cycle
// ALU and a MUL_STAGES-deep pipelined multiplier (MUL/MULH/MULHSU/MULHU). Both
// paths share one registered writeback port toward the CDB arbiter.
//
// The multiplier pipeline never stalls and always has writeback priority. An
// ALU result waits in a one-entry buffer (A) while a multiplier result owns the
// port. New ops are refused while A is occupied and cannot drain this cycle.
// A ROB-age flush kills every younger op at every pipeline position.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   flush_valid/_robid    flush request and the ROB id of the flushing op
//   in_valid / in_ready   issue handshake; op accepted when both are high
//   in_pc, in_is_auipc    left operand is in_pc when in_is_auipc = 1
//   in_imm, in_alu_src    right operand is in_imm when in_alu_src = 1
//   in_alu_op             ALU function (0 ADD .. 10 PASS_R, 11-15 give 0)
//   in_is_mul, in_mul_op  route to multiplier; 0 MUL 1 MULH 2 MULHSU 3 MULHU
//   in_rs1, in_rs2        source operand values
//   in_prd, in_robid      destination physical register and ROB id
//   in_reg_write          op writes its destination register
//   wb_valid .. wb_data   registered writeback port
// -----------------------------------------------------------------------------
module int_mul_alu_shared_wb #(
  parameter int XLEN       = 32,
  parameter int PRF_WIDTH  = 6,
  parameter int ROB_WIDTH  = 5,
  parameter int MUL_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_valid,
  input  logic [ROB_WIDTH:0]   flush_robid,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 in_is_auipc,
  input  logic                 in_alu_src,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [3:0]           in_alu_op,
  input  logic                 in_is_mul,
  input  logic [1:0]           in_mul_op,
  input  logic [XLEN-1:0]      in_rs1,
  input  logic [XLEN-1:0]      in_rs2,
  input  logic [PRF_WIDTH-1:0] in_prd,
  input  logic [ROB_WIDTH:0]   in_robid,
  input  logic                 in_reg_write,
  output logic                 wb_valid,
  output logic                 wb_need_to_wb,
  output logic [PRF_WIDTH-1:0] wb_prd,
  output logic [ROB_WIDTH:0]   wb_robid,
  output logic [XLEN-1:0]      wb_data
);

  localparam int SHW = $clog2(XLEN);
  localparam int PW  = 2 * XLEN + 2;

  // ROB ids carry a phase bit above the index. When the phases differ the
  // index comparison is inverted, so wrapped ids still order correctly.
  function automatic logic is_younger(input logic [ROB_WIDTH:0] r,
                                      input logic [ROB_WIDTH:0] f);
    return r[ROB_WIDTH] ^ f[ROB_WIDTH] ^
           (r[ROB_WIDTH-1:0] > f[ROB_WIDTH-1:0]);
  endfunction

  // ---------------------------------------------------------------------------
  // Operand selection (shared by both paths)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] opnd_l;
  logic [XLEN-1:0] opnd_r;
  logic [SHW-1:0]  shamt;

  assign opnd_l = in_is_auipc ? in_pc : in_rs1;
  assign opnd_r = in_alu_src ? in_imm : in_rs2;
  assign shamt  = opnd_r[SHW-1:0];

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] alu_result;

  always_comb begin
    alu_result = '0;
    case (in_alu_op)
      4'd0:    alu_result = opnd_l + opnd_r;
      4'd1:    alu_result = opnd_l - opnd_r;
      4'd2:    alu_result = opnd_l << shamt;
      4'd3:    alu_result = {{(XLEN-1){1'b0}}, ($signed(opnd_l) < $signed(opnd_r))};
      4'd4:    alu_result = {{(XLEN-1){1'b0}}, (opnd_l < opnd_r)};
      4'd5:    alu_result = opnd_l ^ opnd_r;
      4'd6:    alu_result = opnd_l >> shamt;
      4'd7:    alu_result = XLEN'($signed(opnd_l) >>> shamt);
      4'd8:    alu_result = opnd_l | opnd_r;
      4'd9:    alu_result = opnd_l & opnd_r;
      4'd10:   alu_result = opnd_r;
      default: alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier front end. Both operands are extended to 2*XLEN+2 bits with a
  // per-variant sign, so a single signed multiply covers all four variants.
  // The product is computed at issue and then carried down the stage chain,
  // leaving the register chain free for retiming to balance the multiplier.
  // ---------------------------------------------------------------------------
  logic                 l_signed;
  logic                 r_signed;
  logic signed [PW-1:0] mul_l_ext;
  logic signed [PW-1:0] mul_r_ext;
  logic signed [PW-1:0] mul_full;
  logic [XLEN-1:0]      mul_result;

  assign l_signed   = (in_mul_op == 2'd1) || (in_mul_op == 2'd2);
  assign r_signed   = (in_mul_op == 2'd1);
  assign mul_l_ext  = {{(XLEN+2){l_signed & opnd_l[XLEN-1]}}, opnd_l};
  assign mul_r_ext  = {{(XLEN+2){r_signed & opnd_r[XLEN-1]}}, opnd_r};
  assign mul_full   = mul_l_ext * mul_r_ext;
  assign mul_result = (in_mul_op == 2'd0) ? mul_full[XLEN-1:0]
                                          : mul_full[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------------------
  // Issue handshake
  // ---------------------------------------------------------------------------
  logic a_valid_reg;
  logic tail_valid;
  logic accept;
  logic in_kill;
  logic mul_accept;
  logic alu_accept;

  // Raw (pre-flush) valids: a younger-killed tail still blocks issue this
  // cycle, which keeps in_ready independent of the flush compare.
  assign in_ready   = ~reset & (~a_valid_reg | ~tail_valid);
  assign accept     = in_valid & in_ready;
  assign in_kill    = flush_valid & is_younger(in_robid, flush_robid);
  assign mul_accept = accept & in_is_mul & ~in_kill;
  assign alu_accept = accept & ~in_is_mul & ~in_kill;

  // ---------------------------------------------------------------------------
  // Multiplier stage chain (index 1 = entry, MUL_STAGES = tail)
  // ---------------------------------------------------------------------------
  logic                 stg_valid_reg [1:MUL_STAGES];
  logic [XLEN-1:0]      stg_data_reg  [1:MUL_STAGES];
  logic [PRF_WIDTH-1:0] stg_prd_reg   [1:MUL_STAGES];
  logic [ROB_WIDTH:0]   stg_robid_reg [1:MUL_STAGES];
  logic [MUL_STAGES:1]  stg_live;

  // An entry is live when valid and not killed by a flush this cycle.
  for (genvar gi = 1; gi <= MUL_STAGES; gi++) begin : gen_stg_live
    assign stg_live[gi] = stg_valid_reg[gi] &
                          ~(flush_valid & is_younger(stg_robid_reg[gi], flush_robid));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= MUL_STAGES; i++) begin
        stg_valid_reg[i] <= 1'b0;
      end
    end else begin
      stg_valid_reg[1] <= mul_accept;
      for (int i = 2; i <= MUL_STAGES; i++) begin
        stg_valid_reg[i] <= stg_live[i-1];
      end
    end
    // Payload needs no reset; it is qualified by the valids.
    stg_data_reg[1]  <= mul_result;
    stg_prd_reg[1]   <= in_prd;
    stg_robid_reg[1] <= in_robid;
    for (int i = 2; i <= MUL_STAGES; i++) begin
      stg_data_reg[i]  <= stg_data_reg[i-1];
      stg_prd_reg[i]   <= stg_prd_reg[i-1];
      stg_robid_reg[i] <= stg_robid_reg[i-1];
    end
  end

  logic tail_live;

  assign tail_valid = stg_valid_reg[MUL_STAGES];
  assign tail_live  = stg_live[MUL_STAGES];

  // ---------------------------------------------------------------------------
  // ALU buffer A
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]      a_data_reg;
  logic [PRF_WIDTH-1:0] a_prd_reg;
  logic [ROB_WIDTH:0]   a_robid_reg;
  logic                 a_reg_write_reg;
  logic                 a_live;
  logic                 a_valid_next;

  assign a_live = a_valid_reg & ~(flush_valid & is_younger(a_robid_reg, flush_robid));

  // A survives only when it is live and blocked by a live tail. A new ALU op
  // can refill it on the same edge it drains.
  always_comb begin
    a_valid_next = a_live & tail_live;
    if (alu_accept) begin
      a_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_reg <= 1'b0;
    end else begin
      a_valid_reg <= a_valid_next;
    end
    if (alu_accept) begin
      a_data_reg      <= alu_result;
      a_prd_reg       <= in_prd;
      a_robid_reg     <= in_robid;
      a_reg_write_reg <= in_reg_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback register: live tail first, then live A, else empty
  // ---------------------------------------------------------------------------
  logic                 wb_valid_reg;
  logic                 wb_need_reg;
  logic [PRF_WIDTH-1:0] wb_prd_reg;
  logic [ROB_WIDTH:0]   wb_robid_reg;
  logic [XLEN-1:0]      wb_data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_reg <= 1'b0;
      wb_need_reg  <= 1'b0;
      wb_prd_reg   <= '0;
      wb_robid_reg <= '0;
      wb_data_reg  <= '0;
    end else if (tail_live) begin
      wb_valid_reg <= 1'b1;
      wb_need_reg  <= 1'b1;
      wb_prd_reg   <= stg_prd_reg[MUL_STAGES];
      wb_robid_reg <= stg_robid_reg[MUL_STAGES];
      wb_data_reg  <= stg_data_reg[MUL_STAGES];
    end else if (a_live) begin
      wb_valid_reg <= 1'b1;
      wb_need_reg  <= a_reg_write_reg;
      wb_prd_reg   <= a_prd_reg;
      wb_robid_reg <= a_robid_reg;
      wb_data_reg  <= a_data_reg;
    end else begin
      wb_valid_reg <= 1'b0;
    end
  end

  // A flush arriving while the result sits in the register masks it at once;
  // the register is reloaded next edge, so the entry is dropped.
  assign wb_valid      = wb_valid_reg &
                         ~(flush_valid & is_younger(wb_robid_reg, flush_robid));
  assign wb_need_to_wb = wb_need_reg;
  assign wb_prd        = wb_prd_reg;
  assign wb_robid      = wb_robid_reg;
  assign wb_data       = wb_data_reg;

endmodule
